// File: rtl/alu_mc_pkg.sv
// ---------------------------------------------------------------------------
// alu_mc_pkg : shared ALU op encodings and helpers for alu_mc. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_mc_pkg;

   localparam int ALU_OP_W = 5;

   // Legacy 4-bit single-cycle codes, zero-extended to 5 bits.
   localparam logic [ALU_OP_W-1:0] ALU_AND   = 5'd0;
   localparam logic [ALU_OP_W-1:0] ALU_OR    = 5'd1;
   localparam logic [ALU_OP_W-1:0] ALU_ADD   = 5'd2;
   localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 5'd3;
   localparam logic [ALU_OP_W-1:0] ALU_SLL   = 5'd4;
   localparam logic [ALU_OP_W-1:0] ALU_SRL   = 5'd5;
   localparam logic [ALU_OP_W-1:0] ALU_SUB   = 5'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SLT   = 5'd7;
   localparam logic [ALU_OP_W-1:0] ALU_NOR   = 5'd12;

   localparam logic [ALU_OP_W-1:0] ALU_XOR   = 5'd16;
   localparam logic [ALU_OP_W-1:0] ALU_SRA   = 5'd17;
   localparam logic [ALU_OP_W-1:0] ALU_MULT  = 5'd18;
   localparam logic [ALU_OP_W-1:0] ALU_MULTU = 5'd19;
   localparam logic [ALU_OP_W-1:0] ALU_DIV   = 5'd20;
   localparam logic [ALU_OP_W-1:0] ALU_DIVU  = 5'd21;

   // Counter must hold the value WIDTH itself, hence one extra bit.
   function automatic int cnt_bits(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mc_seq.sv
// ---------------------------------------------------------------------------
// alu_mc_seq : iterative shift-add multiply / restoring divide core on
// unsigned magnitudes. Divide path present only with ALU_MC_DIV_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_mc_seq
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
`ifdef ALU_MC_DIV_EN
   input  logic             div_i,
`endif
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             last_o
);

   localparam int CW = cnt_bits(WIDTH);

   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ALU_MC_DIV_EN
   logic             div_q, div_d;
`endif

   logic [WIDTH:0]   add_a, add_b, sum;
   logic             cin;

   // Single adder shared by both algorithms: add for mult, subtract for div.
   always_comb begin
      add_a = {1'b0, hi_q};
      add_b = lo_q[0] ? {1'b0, m_q} : '0;
      cin   = 1'b0;
`ifdef ALU_MC_DIV_EN
      if (div_q) begin
         add_a = {hi_q, lo_q[WIDTH-1]};
         add_b = ~{1'b0, m_q};
         cin   = 1'b1;
      end
`endif
   end

   assign sum = add_a + add_b + (WIDTH+1)'(cin);

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      m_d   = m_q;
      cnt_d = cnt_q;
`ifdef ALU_MC_DIV_EN
      div_d = div_q;
`endif
      if (load_i) begin
         hi_d  = '0;
         cnt_d = CW'(WIDTH);
`ifdef ALU_MC_DIV_EN
         div_d = div_i;
         lo_d  = div_i ? a_i : b_i;
         m_d   = div_i ? b_i : a_i;
`else
         lo_d  = b_i;
         m_d   = a_i;
`endif
      end else if (step_i) begin
         cnt_d = cnt_q - CW'(1);
`ifdef ALU_MC_DIV_EN
         if (div_q) begin
            // Borrow out (sum MSB) means the trial subtraction went negative: restore.
            if (sum[WIDTH]) begin
               hi_d = add_a[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
               hi_d = sum[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end
         end else
`endif
         begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q  <= '0;
         lo_q  <= '0;
         m_q   <= '0;
         cnt_q <= '0;
`ifdef ALU_MC_DIV_EN
         div_q <= 1'b0;
`endif
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
`ifdef ALU_MC_DIV_EN
         div_q <= div_d;
`endif
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign last_o = (cnt_q == CW'(1));

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc : multi-cycle ALU with start/busy/done handshake and HI/LO pair.
// Optional divider enabled by macro ALU_MC_DIV_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ALU_OP_W-1:0] ALUOp,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   output logic                busy,
   output logic                done,
   output logic [WIDTH-1:0]    C,
   output logic [WIDTH-1:0]    HI,
   output logic [WIDTH-1:0]    LO,
   output logic                Zero,
   output logic                DivZero
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             zero_q, zero_d;
   logic             dz_q, dz_d;
   logic             neg_q, neg_d;
`ifdef ALU_MC_DIV_EN
   logic             rneg_q, rneg_d;
   logic             isdiv_q, isdiv_d;
`endif

   logic [WIDTH-1:0]   alu_res;
   logic [SHW-1:0]     shamt;
   logic               op_signed;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               seq_load, seq_step;
   logic [WIDTH-1:0]   seq_hi, seq_lo;
   logic               seq_last;
   logic [2*WIDTH-1:0] prod_raw, prod_fix;
`ifdef ALU_MC_DIV_EN
   logic               seq_div;
`endif

   assign shamt = A[SHW-1:0];

   always_comb begin
      alu_res = A;
      case (ALUOp)
         ALU_AND:  alu_res = A & B;
         ALU_OR:   alu_res = A | B;
         ALU_ADD:  alu_res = A + B;
         ALU_SUB:  alu_res = A - B;
         ALU_NOR:  alu_res = ~(A | B);
         ALU_XOR:  alu_res = A ^ B;
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
         ALU_SLL:  alu_res = B << shamt;
         ALU_SRL:  alu_res = B >> shamt;
         ALU_SRA:  alu_res = $signed(B) >>> shamt;
         default:  alu_res = A;
      endcase
   end

   // The core works on magnitudes; signs are reapplied in FIX.
   assign op_signed = (ALUOp == ALU_MULT) || (ALUOp == ALU_DIV);
   assign a_mag     = (op_signed && A[WIDTH-1]) ? -A : A;
   assign b_mag     = (op_signed && B[WIDTH-1]) ? -B : B;

   assign prod_raw = {seq_hi, seq_lo};
   assign prod_fix = neg_q ? -prod_raw : prod_raw;

   alu_mc_seq #(
      .WIDTH (WIDTH)
   ) u_seq (
      .clk    (clk),
      .rst    (rst),
      .load_i (seq_load),
`ifdef ALU_MC_DIV_EN
      .div_i  (seq_div),
`endif
      .step_i (seq_step),
      .a_i    (a_mag),
      .b_i    (b_mag),
      .hi_o   (seq_hi),
      .lo_o   (seq_lo),
      .last_o (seq_last)
   );

   always_comb begin
      state_d  = state_q;
      c_d      = c_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      zero_d   = zero_q;
      dz_d     = dz_q;
      neg_d    = neg_q;
      seq_load = 1'b0;
      seq_step = 1'b0;
`ifdef ALU_MC_DIV_EN
      rneg_d   = rneg_q;
      isdiv_d  = isdiv_q;
      seq_div  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (ALUOp)
                  ALU_MULT, ALU_MULTU: begin
                     seq_load = 1'b1;
                     neg_d    = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef ALU_MC_DIV_EN
                     isdiv_d  = 1'b0;
`endif
                     state_d  = S_MUL;
                  end
                  ALU_DIV, ALU_DIVU: begin
`ifdef ALU_MC_DIV_EN
                     if (B == '0) begin
                        hi_d    = A;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                     end else begin
                        seq_load = 1'b1;
                        seq_div  = 1'b1;
                        neg_d    = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        rneg_d   = op_signed & A[WIDTH-1];
                        isdiv_d  = 1'b1;
                        state_d  = S_DIV;
                     end
`else
                     // Divide not built: report as unsupported.
                     hi_d    = '0;
                     lo_d    = '0;
                     dz_d    = 1'b1;
                     state_d = S_DONE;
`endif
                  end
                  default: begin
                     c_d     = alu_res;
                     zero_d  = (alu_res == '0);
                     state_d = S_DONE;
                  end
               endcase
            end
         end
         S_MUL: begin
            seq_step = 1'b1;
            if (seq_last) state_d = S_FIX;
         end
`ifdef ALU_MC_DIV_EN
         S_DIV: begin
            seq_step = 1'b1;
            if (seq_last) state_d = S_FIX;
         end
`endif
         S_FIX: begin
`ifdef ALU_MC_DIV_EN
            if (isdiv_q) begin
               lo_d = neg_q  ? -seq_lo : seq_lo;
               hi_d = rneg_q ? -seq_hi : seq_hi;
               dz_d = 1'b0;
            end else
`endif
            begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         c_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         zero_q  <= 1'b1;
         dz_q    <= 1'b0;
         neg_q   <= 1'b0;
`ifdef ALU_MC_DIV_EN
         rneg_q  <= 1'b0;
         isdiv_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         zero_q  <= zero_d;
         dz_q    <= dz_d;
         neg_q   <= neg_d;
`ifdef ALU_MC_DIV_EN
         rneg_q  <= rneg_d;
         isdiv_q <= isdiv_d;
`endif
      end
   end

   assign busy    = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
   assign done    = (state_q == S_DONE);
   assign C       = c_q;
   assign HI      = hi_q;
   assign LO      = lo_q;
   assign Zero    = zero_q;
   assign DivZero = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc : directed self-checking bench for alu_mc (WIDTH=32). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_mc;
   import alu_mc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  ALUOp;
   logic [31:0] A, B;
   logic        busy, done;
   logic [31:0] C, HI, LO;
   logic        Zero, DivZero;

   int checks = 0;
   int errors = 0;
   int lat;
   int ndone;
   logic [31:0] got_hi, got_lo;

   alu_mc #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .ALUOp   (ALUOp),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .C       (C),
      .HI      (HI),
      .LO      (LO),
      .Zero    (Zero),
      .DivZero (DivZero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   // Launch one op and wait (bounded) for done; lat counts cycles from start.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int l);
      @(negedge clk);
      ALUOp = op; A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      l = 1;
      while (done !== 1'b1 && l < 100) begin
         @(negedge clk);
         l++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ALUOp = '0; A = '0; B = '0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_C", C, 32'd0);
      chk("rst_HI", HI, 32'd0);
      chk("rst_LO", LO, 32'd0);
      chk("rst_Zero", {31'd0, Zero}, 32'd1);
      chk("rst_DivZero", {31'd0, DivZero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(ALU_ADD, 32'd7, 32'hFFFF_FFFD, lat);
      chk("add_lat", lat, 1);
      chk("add_C", C, 32'd4);
      chk("add_Zero", {31'd0, Zero}, 32'd0);
      chk("add_HI", HI, 32'd0);
      chk("add_LO", LO, 32'd0);
      @(negedge clk);
      chk("add_done_pulse", {31'd0, done}, 32'd0);

      run_op(ALU_SUB, 32'd5, 32'd5, lat);
      chk("sub_C", C, 32'd0);
      chk("sub_Zero", {31'd0, Zero}, 32'd1);

      run_op(ALU_SRA, 32'd4, 32'h8000_0000, lat);
      chk("sra_C", C, 32'hF800_0000);
      run_op(ALU_SRL, 32'd8, 32'h8000_0000, lat);
      chk("srl_C", C, 32'h0080_0000);
      run_op(ALU_SLL, 32'd36, 32'd1, lat);
      chk("sll_C", C, 32'h0000_0010);
      run_op(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, lat);
      chk("sltu_C", C, 32'd1);
      run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, lat);
      chk("slt_C", C, 32'd1);
      run_op(ALU_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, lat);
      chk("nor_C", C, 32'h0000_0F0F);
      run_op(ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, lat);
      chk("xor_C", C, 32'hF0F0_F0F0);
      run_op(5'd31, 32'h1234_5678, 32'd9, lat);
      chk("undef_lat", lat, 1);
      chk("undef_C", C, 32'h1234_5678);

      run_op(ALU_MULT, 32'hFFFF_FFFA, 32'd7, lat);
      chk("mult_lat", lat, 34);
      chk("mult_HI", HI, 32'hFFFF_FFFF);
      chk("mult_LO", LO, 32'hFFFF_FFD6);
      chk("mult_C_held", C, 32'h1234_5678);

`ifdef ALU_MC_DIV_EN
      run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, lat);
      chk("div_lat", lat, 34);
      chk("div_LO", LO, 32'hFFFF_FFFD);
      chk("div_HI", HI, 32'hFFFF_FFFF);
      chk("div_DivZero", {31'd0, DivZero}, 32'd0);
      run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      chk("divovf_LO", LO, 32'h8000_0000);
      chk("divovf_HI", HI, 32'd0);
      chk("divovf_DivZero", {31'd0, DivZero}, 32'd0);
      run_op(ALU_DIVU, 32'd5, 32'd0, lat);
      chk("divu0_lat", lat, 1);
      chk("divu0_LO", LO, 32'hFFFF_FFFF);
      chk("divu0_HI", HI, 32'd5);
      chk("divu0_DivZero", {31'd0, DivZero}, 32'd1);
`else
      run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, lat);
      chk("div_lat", lat, 1);
      chk("div_LO", LO, 32'd0);
      chk("div_HI", HI, 32'd0);
      chk("div_DivZero", {31'd0, DivZero}, 32'd1);
      run_op(ALU_DIVU, 32'd5, 32'd0, lat);
      chk("divu0_lat", lat, 1);
      chk("divu0_LO", LO, 32'd0);
      chk("divu0_HI", HI, 32'd0);
      chk("divu0_DivZero", {31'd0, DivZero}, 32'd1);
`endif

      run_op(ALU_MULTU, 32'hFFFF_FFFF, 32'd2, lat);
      chk("multu_lat", lat, 34);
      chk("multu_HI", HI, 32'd1);
      chk("multu_LO", LO, 32'hFFFF_FFFE);
      chk("multu_DivZero_held", {31'd0, DivZero}, 32'd1);

      // Reset asserted in the middle of a multiply.
      @(negedge clk);
      ALUOp = ALU_MULT; A = 32'd3; B = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) @(negedge clk);
      chk("midrst_busy_before", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_HI", HI, 32'd0);
      chk("midrst_LO", LO, 32'd0);
      chk("midrst_DivZero", {31'd0, DivZero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(ALU_ADD, 32'd2, 32'd2, lat);
      chk("postrst_add_lat", lat, 1);
      chk("postrst_add_C", C, 32'd4);

      // start held high with changing operands while the first op runs.
      @(negedge clk);
`ifdef ALU_MC_DIV_EN
      ALUOp = ALU_DIV;
`else
      ALUOp = ALU_MULTU;
`endif
      A = 32'd100; B = 32'd7; start = 1'b1;
      ndone = 0; lat = 0; got_hi = '0; got_lo = '0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (ndone == 0) lat++;
         if (done === 1'b1) begin
            ndone++;
            got_hi = HI;
            got_lo = LO;
            start  = 1'b0;
         end else if (start) begin
            A = $urandom;
            B = 32'(i + 3);
         end
      end
      chk("pulse_ndone", ndone, 1);
      chk("pulse_lat", lat, 34);
`ifdef ALU_MC_DIV_EN
      chk("pulse_LO", got_lo, 32'd14);
      chk("pulse_HI", got_hi, 32'd2);
`else
      chk("pulse_LO", got_lo, 32'd700);
      chk("pulse_HI", got_hi, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
